sms_boot_loader_ctrl: RTL and testbench

SMS_BOOT_LOADER_CTRL -- requirements
Module: sms_boot_loader_ctrl

---
 rtl/sms_boot_loader_ctrl.sv | 130 +++++++++++++
 tb/tb_sms_boot_loader_ctrl.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sms_boot_loader_ctrl.sv
// Boot loader controller: zero-fills DSRAM, streams loader words into ISRAM,
// then releases the CPU (RUN) or parks in ERR on overflow/timeout.
module sms_boot_loader_ctrl #(
   parameter int DEPTH = 16384,
   parameter int AW    = 14,
   parameter int TMO   = 65535
) (
   input  logic          hclk,
   input  logic          hrst_b,
   input  logic          load_wvalid,
   input  logic [31:0]   load_wdata,
   input  logic          load_wlast,
   output logic          load_wready,
   output logic          isram_cen,
   output logic [3:0]    isram_wen,
   output logic [AW-1:0] isram_addr,
   output logic [31:0]   isram_din,
   output logic          dsram_cen,
   output logic [3:0]    dsram_wen,
   output logic [AW-1:0] dsram_addr,
   output logic [31:0]   dsram_din,
   output logic          ctrl_own,
   output logic          cpu_rst_b,
   output logic          boot_done,
   output logic          boot_err
);

   localparam logic [1:0] CLEAR = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] RUN   = 2'd2;
   localparam logic [1:0] ERR   = 2'd3;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [15:0]   TMO_LAST  = 16'(TMO - 1);

   logic [1:0]    state;
   logic [AW-1:0] ld_cnt;
   logic [15:0]   tmo_cnt;
   logic          fin_run;
   logic          fin_err;
   logic          accept;

   // The final word's ISRAM write goes out while still in LOAD (fin_* pending),
   // so ownership is only handed to the CPU once that write has been issued.
   assign load_wready = (state == LOAD) && !fin_run && !fin_err;
   assign accept      = load_wvalid && load_wready;
   assign ctrl_own    = (state != RUN);
   assign boot_done   = (state == RUN);
   assign boot_err    = (state == ERR);
   assign dsram_din   = '0;

   always_ff @(posedge hclk or negedge hrst_b) begin
      if (!hrst_b) begin
         state      <= CLEAR;
         ld_cnt     <= '0;
         tmo_cnt    <= '0;
         fin_run    <= 1'b0;
         fin_err    <= 1'b0;
         dsram_cen  <= 1'b1;
         dsram_wen  <= '1;
         dsram_addr <= '0;
      end else begin
         case (state)
            CLEAR: begin
               if (!dsram_cen && (dsram_addr == LAST_ADDR)) begin
                  state      <= LOAD;
                  dsram_cen  <= 1'b1;
                  dsram_wen  <= '1;
                  dsram_addr <= '0;
                  tmo_cnt    <= '0;
               end else begin
                  dsram_cen  <= 1'b0;
                  dsram_wen  <= '0;
                  dsram_addr <= dsram_cen ? '0 : dsram_addr + AW'(1);
               end
            end
            LOAD: begin
               if (fin_run) begin
                  state <= RUN;
               end else if (fin_err) begin
                  state <= ERR;
               end else if (accept) begin
                  tmo_cnt <= '0;
                  if (load_wlast) begin
                     fin_run <= 1'b1;
                  end else if (ld_cnt == LAST_ADDR) begin
                     fin_err <= 1'b1;
                  end else begin
                     ld_cnt <= ld_cnt + AW'(1);
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
                  if (tmo_cnt == TMO_LAST) begin
                     state <= ERR;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge hclk or negedge hrst_b) begin
      if (!hrst_b) begin
         cpu_rst_b <= 1'b0;
      end else begin
         cpu_rst_b <= (state == RUN);
      end
   end

   // Lane n of the SRAM word takes loader byte n counted from the MSB.
   always_ff @(posedge hclk or negedge hrst_b) begin
      if (!hrst_b) begin
         isram_cen  <= 1'b1;
         isram_wen  <= '1;
         isram_addr <= '0;
         isram_din  <= '0;
      end else if (accept) begin
         isram_cen  <= 1'b0;
         isram_wen  <= '0;
         isram_addr <= ld_cnt;
         isram_din  <= {load_wdata[7:0], load_wdata[15:8], load_wdata[23:16], load_wdata[31:24]};
      end else begin
         isram_cen  <= 1'b1;
         isram_wen  <= '1;
      end
   end

endmodule

// File: tb/tb_sms_boot_loader_ctrl.sv
// Randomized self-checking bench for sms_boot_loader_ctrl (DEPTH=16, AW=4, TMO=8).
module tb_sms_boot_loader_ctrl;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int TMO   = 8;

   logic          hclk = 1'b0;
   logic          hrst_b;
   logic          load_wvalid;
   logic [31:0]   load_wdata;
   logic          load_wlast;
   logic          load_wready;
   logic          isram_cen;
   logic [3:0]    isram_wen;
   logic [AW-1:0] isram_addr;
   logic [31:0]   isram_din;
   logic          dsram_cen;
   logic [3:0]    dsram_wen;
   logic [AW-1:0] dsram_addr;
   logic [31:0]   dsram_din;
   logic          ctrl_own;
   logic          cpu_rst_b;
   logic          boot_done;
   logic          boot_err;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 hclk = ~hclk;

   sms_boot_loader_ctrl #(.DEPTH(DEPTH), .AW(AW), .TMO(TMO)) dut (
      .hclk(hclk), .hrst_b(hrst_b),
      .load_wvalid(load_wvalid), .load_wdata(load_wdata), .load_wlast(load_wlast),
      .load_wready(load_wready),
      .isram_cen(isram_cen), .isram_wen(isram_wen), .isram_addr(isram_addr), .isram_din(isram_din),
      .dsram_cen(dsram_cen), .dsram_wen(dsram_wen), .dsram_addr(dsram_addr), .dsram_din(dsram_din),
      .ctrl_own(ctrl_own), .cpu_rst_b(cpu_rst_b), .boot_done(boot_done), .boot_err(boot_err)
   );

   // Bus monitor: logs every SRAM write presented during a cycle.
   logic [AW-1:0] ds_addr[$];
   logic [AW-1:0] is_addr[$];
   logic [31:0]   is_data[$];
   int ds_bad = 0;
   int is_bad = 0;

   always @(negedge hclk) begin
      if (hrst_b === 1'b1) begin
         if (dsram_cen === 1'b0) begin
            ds_addr.push_back(dsram_addr);
            if (dsram_wen !== 4'h0 || dsram_din !== 32'h0) ds_bad++;
         end
         if (isram_cen === 1'b0) begin
            is_addr.push_back(isram_addr);
            is_data.push_back(isram_din);
            if (isram_wen !== 4'h0 || ctrl_own !== 1'b1) is_bad++;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge hclk);
      #1;
   endtask

   task automatic clear_logs();
      ds_addr.delete();
      is_addr.delete();
      is_data.delete();
      ds_bad = 0;
      is_bad = 0;
   endtask

   task automatic apply_reset(input logic valid_hi);
      hrst_b      = 1'b0;
      load_wvalid = valid_hi;
      load_wlast  = 1'b0;
      load_wdata  = $urandom;
      tick();
      tick();
      clear_logs();
      hrst_b = 1'b1;
   endtask

   task automatic wait_load(input int budget, output int n);
      n = 0;
      while (load_wready !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
   endtask

   task automatic idle(input int n);
      load_wvalid = 1'b0;
      load_wlast  = 1'b0;
      repeat (n) tick();
   endtask

   task automatic drive_word(input logic [31:0] d, input logic last, input int budget, output bit ok);
      int waited = 0;
      ok          = 1'b0;
      load_wvalid = 1'b1;
      load_wdata  = d;
      load_wlast  = last;
      while (!ok && waited < budget) begin
         if (load_wready === 1'b1) ok = 1'b1;
         tick();
         waited++;
      end
      load_wvalid = 1'b0;
      load_wlast  = 1'b0;
   endtask

   // Byte n of the word (MSB first) belongs in SRAM lane n, i.e. din[8n+7:8n].
   function automatic logic [31:0] lane_pack(input logic [31:0] w);
      logic [31:0] r;
      logic [7:0]  b;
      r = '0;
      for (int unsigned n = 0; n < 4; n++) begin
         b = 8'((w >> (24 - 8 * n)) & 32'hFF);
         r = r | (32'(b) << (8 * n));
      end
      return r;
   endfunction

   // Session model: gaps[k] idle cycles precede word k.
   logic [31:0] words[$];
   logic        lasts[$];
   int          gaps[$];

   function automatic void predict(input int n, output int nacc, output int outcome);
      nacc    = 0;
      outcome = 2;
      for (int k = 0; k < n; k++) begin
         if (gaps[k] >= TMO) return;
         nacc++;
         if (lasts[k]) begin
            outcome = 1;
            return;
         end
         if (nacc == DEPTH) return;
      end
   endfunction

   task automatic test_reset();
      hrst_b      = 1'b0;
      load_wvalid = 1'b1;
      load_wlast  = 1'b1;
      load_wdata  = $urandom;
      tick();
      tick();
      tests_run++;
      if (load_wready !== 1'b0) begin
         tests_failed++; $display("FAIL reset_ready: got %b expected 0", load_wready);
      end
      tests_run++;
      if ({isram_cen, dsram_cen} !== 2'b11) begin
         tests_failed++; $display("FAIL reset_cen: got %b expected 11", {isram_cen, dsram_cen});
      end
      tests_run++;
      if ({isram_wen, dsram_wen} !== 8'hFF) begin
         tests_failed++; $display("FAIL reset_wen: got %h expected ff", {isram_wen, dsram_wen});
      end
      tests_run++;
      if ({isram_addr, dsram_addr, isram_din, dsram_din} !== '0) begin
         tests_failed++; $display("FAIL reset_addr_din: got %h expected 0", {isram_addr, dsram_addr, isram_din, dsram_din});
      end
      tests_run++;
      if ({ctrl_own, cpu_rst_b, boot_done, boot_err} !== 4'b1000) begin
         tests_failed++; $display("FAIL reset_status: got %b expected 1000", {ctrl_own, cpu_rst_b, boot_done, boot_err});
      end
      load_wvalid = 1'b0;
      load_wlast  = 1'b0;
   endtask

   task automatic test_clear();
      int n;
      int bad = 0;
      apply_reset(1'b0);
      wait_load(40, n);
      tests_run++;
      if (n !== DEPTH + 1) begin
         tests_failed++; $display("FAIL clear_ready_cycle: got %0d expected %0d", n, DEPTH + 1);
      end
      tests_run++;
      if (ds_addr.size() !== DEPTH) begin
         tests_failed++; $display("FAIL clear_write_count: got %0d expected %0d", ds_addr.size(), DEPTH);
      end
      foreach (ds_addr[i]) if (int'(ds_addr[i]) != i) bad++;
      tests_run++;
      if (bad !== 0 || ds_bad !== 0) begin
         tests_failed++; $display("FAIL clear_addr_order: got %0d bad writes expected 0", bad + ds_bad);
      end
      tests_run++;
      if ({dsram_cen, ctrl_own, cpu_rst_b, is_addr.size() == 0} !== 4'b1101) begin
         tests_failed++; $display("FAIL clear_exit: got %b expected 1101", {dsram_cen, ctrl_own, cpu_rst_b, is_addr.size() == 0});
      end
   endtask

   task automatic test_load_last();
      logic [31:0] w[3];
      int n;
      int bad = 0;
      bit ok;
      w[0] = 32'h11223344; w[1] = 32'h55667788; w[2] = 32'h99AABBCC;
      apply_reset(1'b0);
      wait_load(40, n);
      for (int k = 0; k < 3; k++) begin
         drive_word(w[k], k == 2, 4, ok);
         tests_run++;
         if (!ok) begin
            tests_failed++; $display("FAIL load_accept_%0d: got not accepted expected accepted", k);
         end
      end
      n = 0;
      while (boot_done !== 1'b1 && n < 4) begin tick(); n++; end
      tests_run++;
      if ({boot_done, ctrl_own, cpu_rst_b, isram_cen} !== 4'b1001) begin
         tests_failed++; $display("FAIL run_entry: got %b expected 1001", {boot_done, ctrl_own, cpu_rst_b, isram_cen});
      end
      tick();
      tests_run++;
      if ({cpu_rst_b, boot_done, boot_err, ctrl_own} !== 4'b1100) begin
         tests_failed++; $display("FAIL run_cpu_release: got %b expected 1100", {cpu_rst_b, boot_done, boot_err, ctrl_own});
      end
      tests_run++;
      if (is_addr.size() !== 3 || is_bad !== 0) begin
         tests_failed++; $display("FAIL load_write_count: got %0d expected 3", is_addr.size());
      end else begin
         for (int k = 0; k < 3; k++)
            if (int'(is_addr[k]) != k || is_data[k] !== lane_pack(w[k])) bad++;
         tests_run++;
         if (bad !== 0) begin
            tests_failed++; $display("FAIL load_write_data: got %0d bad words expected 0", bad);
         end
         tests_run++;
         if ({is_data[0][7:0], is_data[0][31:24]} !== 16'h1144) begin
            tests_failed++; $display("FAIL lane_map: got %h expected 1144", {is_data[0][7:0], is_data[0][31:24]});
         end
      end
   endtask

   task automatic test_overflow();
      logic [31:0] w[DEPTH];
      int n;
      int bad = 0;
      bit ok;
      apply_reset(1'b0);
      wait_load(40, n);
      for (int k = 0; k < DEPTH; k++) begin
         w[k] = $urandom;
         idle($urandom_range(0, 3));
         drive_word(w[k], 1'b0, 4, ok);
         if (!ok) bad++;
      end
      tests_run++;
      if (bad !== 0) begin
         tests_failed++; $display("FAIL ovf_accept: got %0d rejected words expected 0", bad);
      end
      n = 0;
      while (boot_err !== 1'b1 && n < 4) begin tick(); n++; end
      tests_run++;
      if ({boot_err, boot_done, ctrl_own, cpu_rst_b} !== 4'b1010) begin
         tests_failed++; $display("FAIL ovf_err: got %b expected 1010", {boot_err, boot_done, ctrl_own, cpu_rst_b});
      end
      drive_word($urandom, 1'b0, 6, ok);
      tests_run++;
      if (ok || load_wready !== 1'b0) begin
         tests_failed++; $display("FAIL ovf_17th_accept: got accepted=%0d expected 0", ok);
      end
      bad = 0;
      foreach (is_addr[i]) if (int'(is_addr[i]) != i || is_data[i] !== lane_pack(w[i])) bad++;
      tests_run++;
      if (is_addr.size() !== DEPTH || bad !== 0 || is_bad !== 0) begin
         tests_failed++; $display("FAIL ovf_writes: got %0d writes (%0d bad) expected %0d", is_addr.size(), bad, DEPTH);
      end
   endtask

   task automatic test_timeout();
      int n;
      bit ok;
      apply_reset(1'b0);
      wait_load(40, n);
      idle(TMO - 1);
      tests_run++;
      if ({boot_err, load_wready} !== 2'b01) begin
         tests_failed++; $display("FAIL tmo_before: got %b expected 01", {boot_err, load_wready});
      end
      idle(1);
      tests_run++;
      if ({boot_err, load_wready, ctrl_own, cpu_rst_b} !== 4'b1010) begin
         tests_failed++; $display("FAIL tmo_err: got %b expected 1010", {boot_err, load_wready, ctrl_own, cpu_rst_b});
      end
      apply_reset(1'b0);
      wait_load(40, n);
      idle(TMO - 1);
      drive_word($urandom, 1'b0, 1, ok);
      tests_run++;
      if (!ok || boot_err !== 1'b0 || load_wready !== 1'b1 || is_addr.size() !== 1) begin
         tests_failed++; $display("FAIL tmo_accept_wins: got ok=%0d err=%b writes=%0d expected 1 0 1", ok, boot_err, is_addr.size());
      end
      idle(TMO - 1);
      drive_word($urandom, 1'b1, 1, ok);
      idle(3);
      tests_run++;
      if (!ok || {boot_done, boot_err} !== 2'b10 || is_addr.size() !== 2) begin
         tests_failed++; $display("FAIL tmo_counter_clears: got ok=%0d done/err=%b writes=%0d expected 1 10 2", ok, {boot_done, boot_err}, is_addr.size());
      end
   endtask

   task automatic test_reset_mid_load();
      logic [31:0] w[5];
      int n;
      int bad = 0;
      bit ok;
      foreach (w[i]) w[i] = $urandom;
      apply_reset(1'b0);
      wait_load(40, n);
      drive_word(w[0], 1'b0, 4, ok);
      drive_word(w[1], 1'b0, 4, ok);
      hrst_b = 1'b0;
      #1;
      tests_run++;
      if ({load_wready, isram_cen, isram_wen, ctrl_own} !== 7'b0111111) begin
         tests_failed++; $display("FAIL async_abort: got %b expected 0111111", {load_wready, isram_cen, isram_wen, ctrl_own});
      end
      tick();
      clear_logs();
      hrst_b = 1'b1;
      wait_load(40, n);
      tests_run++;
      if (n !== DEPTH + 1 || ds_addr.size() !== DEPTH || ds_addr[0] !== '0) begin
         tests_failed++; $display("FAIL reclear: got %0d cycles %0d writes expected %0d %0d", n, ds_addr.size(), DEPTH + 1, DEPTH);
      end
      for (int k = 2; k < 5; k++) drive_word(w[k], k == 4, 4, ok);
      idle(3);
      foreach (is_addr[i]) if (int'(is_addr[i]) != i || is_data[i] !== lane_pack(w[i + 2])) bad++;
      tests_run++;
      if (is_addr.size() !== 3 || bad !== 0 || boot_done !== 1'b1) begin
         tests_failed++; $display("FAIL reload_from_0: got %0d writes (%0d bad) done=%b expected 3 0 1", is_addr.size(), bad, boot_done);
      end
   endtask

   task automatic test_valid_during_clear();
      logic [31:0] d;
      int seen = 0;
      bit ok;
      apply_reset(1'b1);
      d = load_wdata;
      load_wlast = 1'b1;
      for (int c = 0; c < DEPTH; c++) begin
         tick();
         if (load_wready !== 1'b0) seen++;
      end
      tests_run++;
      if (seen !== 0 || is_addr.size() !== 0) begin
         tests_failed++; $display("FAIL clear_no_accept: got %0d ready cycles %0d writes expected 0 0", seen, is_addr.size());
      end
      drive_word(d, 1'b1, 3, ok);
      tests_run++;
      if (!ok || is_addr.size() !== 1 || is_addr[0] !== '0 || is_data[0] !== lane_pack(d)) begin
         tests_failed++; $display("FAIL first_load_write: got ok=%0d writes=%0d expected 1 1 at addr 0", ok, is_addr.size());
      end
   endtask

   task automatic test_random_sessions();
      int n, nacc, outcome, bad;
      bit ok;
      for (int s = 0; s < 6; s++) begin
         int last_at = $urandom_range(0, 20);
         words.delete(); lasts.delete(); gaps.delete();
         for (int k = 0; k < 18; k++) begin
            words.push_back($urandom);
            lasts.push_back(k == last_at);
            gaps.push_back(($urandom_range(0, 11) == 0) ? TMO : $urandom_range(0, TMO - 1));
         end
         predict(18, nacc, outcome);
         apply_reset(1'b0);
         wait_load(40, n);
         bad = 0;
         for (int k = 0; k < nacc; k++) begin
            idle(gaps[k]);
            drive_word(words[k], lasts[k], 2, ok);
            if (!ok) bad++;
         end
         idle(TMO + 3);
         tests_run++;
         if (bad !== 0 || {boot_done, boot_err, cpu_rst_b, ctrl_own} !== {outcome == 1, outcome == 2, outcome == 1, outcome != 1}) begin
            tests_failed++;
            $display("FAIL rand_outcome_%0d: got done/err/rst/own=%b rejected=%0d expected %b 0", s,
                     {boot_done, boot_err, cpu_rst_b, ctrl_own}, bad, {outcome == 1, outcome == 2, outcome == 1, outcome != 1});
         end
         bad = 0;
         foreach (is_addr[i]) if (int'(is_addr[i]) != i || is_data[i] !== lane_pack(words[i])) bad++;
         tests_run++;
         if (is_addr.size() !== nacc || bad !== 0 || is_bad !== 0) begin
            tests_failed++; $display("FAIL rand_writes_%0d: got %0d writes (%0d bad) expected %0d", s, is_addr.size(), bad + is_bad, nacc);
         end
      end
   endtask

   initial begin
      hrst_b      = 1'b0;
      load_wvalid = 1'b0;
      load_wlast  = 1'b0;
      load_wdata  = '0;
      test_reset();
      test_clear();
      test_load_last();
      test_overflow();
      test_timeout();
      test_reset_mid_load();
      test_valid_during_clear();
      test_random_sessions();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
